tekbot_bump_sequencer: RTL and testbench

//  Moore controller that sequences the TekBot drive motors in response to whisker bumps.

---
 rtl/tekbot_bump_sequencer_pkg.sv | 27 ++
 rtl/tekbot_bump_sequencer_if.sv | 12 +
 rtl/tekbot_bump_sequencer_whisker_debounce.sv | 33 +++
 rtl/tekbot_bump_sequencer.sv | 85 ++++++++
 tb/tb_tekbot_bump_sequencer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/tekbot_bump_sequencer_pkg.sv
// tekbot_bump_sequencer_pkg: state codes, motor output patterns and side-latch encoding
package tekbot_bump_sequencer_pkg;
   localparam int MOT_W = 4;
   localparam int ST_W  = 3;
   typedef enum logic [ST_W-1:0] {
      IDLE   = 3'd0,
      FWD    = 3'd1,
      DEAD   = 3'd2,
      BACK   = 3'd3,
      TURN_L = 3'd4,
      TURN_R = 3'd5
   } state_t;
   // {Len,Ldir,Ren,Rdir}: dir 1 = forward, en 1 = motor on
   localparam logic [MOT_W-1:0] MOT_OFF    = 4'b0000;
   localparam logic [MOT_W-1:0] MOT_FWD    = 4'b1111;
   localparam logic [MOT_W-1:0] MOT_BACK   = 4'b1010;
   localparam logic [MOT_W-1:0] MOT_TURN_L = 4'b1011;
   localparam logic [MOT_W-1:0] MOT_TURN_R = 4'b1110;
   // dead-time keeps the direction bits and drops both enables
   localparam logic [MOT_W-1:0] DIR_MASK   = 4'b0101;
   localparam logic SIDE_TURN_L = 1'b0;
   localparam logic SIDE_TURN_R = 1'b1;
   function automatic logic [MOT_W-1:0] mot_code(state_t s);
      return s == FWD ? MOT_FWD : s == BACK ? MOT_BACK :
             s == TURN_L ? MOT_TURN_L : s == TURN_R ? MOT_TURN_R : MOT_OFF;
   endfunction
endpackage

// File: rtl/tekbot_bump_sequencer_if.sv
// tekbot_bump_sequencer_if: run/whisker inputs and motor/status outputs of the sequencer
interface tekbot_bump_sequencer_if;
   import tekbot_bump_sequencer_pkg::*;
   logic             run_i;
   logic             DigitalLDir;
   logic             DigitalRDir;
   logic [MOT_W-1:0] outputs;
   logic [ST_W-1:0]  state_o;
   logic             busy_o;
   modport master (output run_i, DigitalLDir, DigitalRDir, input outputs, state_o, busy_o);
   modport slave  (input run_i, DigitalLDir, DigitalRDir, output outputs, state_o, busy_o);
endinterface

// File: rtl/tekbot_bump_sequencer_whisker_debounce.sv
// tekbot_bump_sequencer_whisker_debounce: 2-FF synchroniser plus tick-sampled debounce
module tekbot_bump_sequencer_whisker_debounce #(
   parameter int DEB_TICKS = 2,
   parameter int CNT_W     = 4
) (
   input  logic clk_i,
   input  logic reset_n,
   input  logic tick_i,
   input  logic i_raw,
   output logic o_level
);
   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   // level flips only after DEB_TICKS consecutive disagreeing tick samples
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_sync  <= 2'b00;
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         if (tick_i) begin
            if (r_sync[1] == r_level) r_cnt <= '0;
            else if (r_cnt == CNT_W'(DEB_TICKS - 1)) begin
               r_level <= ~r_level;
               r_cnt   <= '0;
            end else r_cnt <= r_cnt + 1'b1;
         end
      end
   end
   assign o_level = r_level;
endmodule

// File: rtl/tekbot_bump_sequencer.sv
// tekbot_bump_sequencer: Moore bump/back-up/pivot sequencer with dead-time before reversals
module tekbot_bump_sequencer
   import tekbot_bump_sequencer_pkg::*;
#(
   parameter int DEB_TICKS  = 2,
   parameter int DEAD_TICKS = 1,
   parameter int BACK_TICKS = 5,
   parameter int TURN_TICKS = 3,
   parameter int CNT_W      = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_n,
   input  logic                       tick_i,
   tekbot_bump_sequencer_if.slave     bus
);
   state_t           r_state, r_next;
   logic             r_side, r_busy;
   logic [CNT_W-1:0] r_cnt, w_dur_m1;
   logic [MOT_W-1:0] r_out;
   logic             w_l_deb, w_r_deb, w_exp;
   tekbot_bump_sequencer_whisker_debounce #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_deb_l (
      .clk_i(clk_i), .reset_n(reset_n), .tick_i(tick_i), .i_raw(bus.DigitalLDir), .o_level(w_l_deb));
   tekbot_bump_sequencer_whisker_debounce #(.DEB_TICKS(DEB_TICKS), .CNT_W(CNT_W)) u_deb_r (
      .clk_i(clk_i), .reset_n(reset_n), .tick_i(tick_i), .i_raw(bus.DigitalRDir), .o_level(w_r_deb));
   // last count value of the current timed state; expiry lands on the Nth tick
   always_comb begin
      w_dur_m1 = r_state == DEAD ? CNT_W'(DEAD_TICKS - 1) :
                 r_state == BACK ? CNT_W'(BACK_TICKS - 1) : CNT_W'(TURN_TICKS - 1);
      w_exp    = tick_i && r_cnt == w_dur_m1;
   end
   // state, duration counter, side latch and registered outputs move together
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_next  <= IDLE;
         r_side  <= SIDE_TURN_L;
         r_cnt   <= '0;
         r_out   <= MOT_OFF;
         r_busy  <= 1'b0;
      end else if (!bus.run_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_out   <= MOT_OFF;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= FWD;
               r_out   <= MOT_FWD;
            end
            FWD: if (w_l_deb || w_r_deb) begin
               r_state <= DEAD;
               r_next  <= BACK;
               r_side  <= w_l_deb ? SIDE_TURN_R : SIDE_TURN_L;
               r_out   <= r_out & DIR_MASK;
               r_busy  <= 1'b1;
               r_cnt   <= '0;
            end
            DEAD, BACK, TURN_L, TURN_R: begin
               if (w_exp) begin
                  r_cnt <= '0;
                  if (r_state == DEAD) begin
                     r_state <= r_next;
                     r_out   <= mot_code(r_next);
                     r_busy  <= r_next != FWD;
                  end else begin
                     r_state <= DEAD;
                     r_next  <= r_state != BACK ? FWD : r_side == SIDE_TURN_R ? TURN_R : TURN_L;
                     r_out   <= r_out & DIR_MASK;
                  end
               end else if (tick_i) r_cnt <= r_cnt + 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_out   <= MOT_OFF;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
   assign bus.outputs = r_out;
   assign bus.state_o = r_state;
   assign bus.busy_o  = r_busy;
endmodule

// File: tb/tb_tekbot_bump_sequencer.sv
// tb_tekbot_bump_sequencer: directed scoreboard bench for the bump sequencer
module tb_tekbot_bump_sequencer;
   logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, tick_hold = 1'b0;
   int vectors = 0, miscompares = 0;
   typedef struct {logic [7:0] tup; int ticks;} exp_t;
   exp_t sb[$];

   tekbot_bump_sequencer_if bus();
   tekbot_bump_sequencer dut (.clk_i(clk), .reset_n(rst_n), .tick_i(tick), .bus(bus));

   always #5 clk = ~clk;

   initial begin : tick_gen
      int div = 0;
      forever begin
         @(negedge clk);
         div++;
         tick = tick_hold || (div % 4 == 0);
      end
   end

   function automatic logic [7:0] t8(input logic [3:0] m, input logic [2:0] s, input logic b);
      return {m, s, b};
   endfunction

   function automatic logic [7:0] obs();
      return {bus.outputs, bus.state_o, bus.busy_o};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      vectors++;
      assert (o === e) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] m, input logic [2:0] s, input logic b, input int n);
      exp_t e;
      e.tup   = t8(m, s, b);
      e.ticks = n;
      sb.push_back(e);
   endtask

   task automatic push_seq(input logic [3:0] turn);
      push(4'b0101, 3'd2, 1'b1, 1);
      push(4'b1010, 3'd3, 1'b1, 5);
      push(4'b0000, 3'd2, 1'b1, 1);
      push(turn, turn == 4'b1110 ? 3'd5 : 3'd4, 1'b1, 3);
      push(turn & 4'b0101, 3'd2, 1'b1, 1);
      push(4'b1111, 3'd1, 1'b0, 0);
   endtask

   task automatic follow(input string tag);
      exp_t e;
      logic [7:0] prev;
      int pt, nt, cyc;
      prev = t8(4'b1111, 3'd1, 1'b0);
      pt = 0;
      nt = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cyc = 0;
         while (obs() === prev && cyc < 200) begin
            nt += int'(tick);
            step();
            cyc++;
         end
         if (pt != 0) chk({tag, "_ticks"}, nt, pt);
         chk(tag, obs(), e.tup);
         prev = e.tup;
         pt = e.ticks;
         nt = 0;
      end
   endtask

   task automatic bump(input logic l, input logic r);
      int cyc = 0;
      bus.DigitalLDir = l;
      bus.DigitalRDir = r;
      while (bus.state_o == 3'd1 && cyc < 100) begin
         step();
         cyc++;
      end
      bus.DigitalLDir = 1'b0;
      bus.DigitalRDir = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] s);
      int cyc = 0;
      while (bus.state_o != s && cyc < 200) begin
         step();
         cyc++;
      end
      chk("reach_state", bus.state_o, s);
   endtask

   initial begin
      int n, cyc;
      bus.run_i = 1'b0;
      bus.DigitalLDir = 1'b0;
      bus.DigitalRDir = 1'b0;
      repeat (3) step();
      chk("reset", obs(), 8'h00);
      rst_n = 1'b1;
      repeat (3) step();
      chk("idle_run0", obs(), 8'h00);
      bus.run_i = 1'b1;
      step();
      chk("run_fwd", obs(), t8(4'b1111, 3'd1, 1'b0));
      for (int i = 0; i < 10; i++) begin
         repeat (8) step();
         chk("fwd_hold", obs(), t8(4'b1111, 3'd1, 1'b0));
      end

      bump(1'b1, 1'b0); push_seq(4'b1110); follow("bump_l");
      repeat (12) step();
      bump(1'b0, 1'b1); push_seq(4'b1011); follow("bump_r");
      repeat (12) step();
      bump(1'b1, 1'b1); push_seq(4'b1110); follow("bump_both");
      repeat (12) step();

      for (int g = 0; g < 2; g++) begin
         bus.DigitalLDir = 1'b1;
         repeat (4) step();
         bus.DigitalLDir = 1'b0;
         repeat (16) step();
         chk("glitch", obs(), t8(4'b1111, 3'd1, 1'b0));
      end

      bump(1'b1, 1'b0);
      push_seq(4'b1110);
      fork
         follow("pulse_in_back");
         begin
            cyc = 0;
            while (bus.state_o != 3'd3 && cyc < 100) begin
               step();
               cyc++;
            end
            bus.DigitalRDir = 1'b1;
            repeat (12) step();
            bus.DigitalRDir = 1'b0;
         end
      join
      repeat (12) step();

      tick_hold = 1'b1;
      step();
      bump(1'b1, 1'b0); push_seq(4'b1110); follow("tick_held");
      tick_hold = 1'b0;
      repeat (12) step();

      bump(1'b1, 1'b0);
      wait_state(3'd5);
      n = 0;
      cyc = 0;
      while (cyc < 100) begin
         if (tick) n++;
         if (n == 3) break;
         step();
         cyc++;
      end
      chk("turn_r_last_tick", obs(), t8(4'b1110, 3'd5, 1'b1));
      bus.run_i = 1'b0;
      step();
      chk("stop_at_expiry", obs(), 8'h00);
      repeat (12) step();

      bus.run_i = 1'b1;
      step();
      chk("restart_fwd", obs(), t8(4'b1111, 3'd1, 1'b0));
      bump(1'b1, 1'b0);
      wait_state(3'd3);
      repeat (6) step();
      chk("mid_back", obs(), t8(4'b1010, 3'd3, 1'b1));
      rst_n = 1'b0;
      #1;
      chk("async_reset", obs(), 8'h00);
      repeat (2) step();
      chk("held_reset", obs(), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
